// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster timing generator with a pixel clock-enable divider.
// Fetch-side coordinates lead the sync/blank/RGB outputs by PIPE pixel ticks.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int COORD_W  = 11
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [7:0]         PIXEL_IN,
  output logic [COORD_W-1:0] XCOORD,
  output logic [COORD_W-1:0] YCOORD,
  output logic               FETCH_VALID,
  output logic               PIX_CE,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic [2:0]         R,
  output logic [2:0]         G,
  output logic [1:0]         B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW      = COORD_W + 1;

  // One extra bit so region ends equal to the total never wrap to zero.
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16 || PIPE < 0 || PIPE > 4 ||
        COORD_W < 1 || COORD_W > 30 ||
        H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_params
      $error("vga_timing_gen: illegal parameter set");
    end
  endgenerate

  logic [DIV_W-1:0]   div_q, div_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]         rgb_q, rgb_d;
  logic               hs_q, hs_d, vs_q, vs_d;

  logic div_last, pix_ce, x_last, y_last;
  logic act_raw, hs_raw, vs_raw;
  logic [2:0] cur_flags, out_flags;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign pix_ce   = EN & RST_N & div_last;
  assign x_last   = (x_q == COORD_W'(H_TOTAL - 1));
  assign y_last   = (y_q == COORD_W'(V_TOTAL - 1));

  assign act_raw   = ({1'b0, x_q} < H_ACT_END) && ({1'b0, y_q} < V_ACT_END);
  assign hs_raw    = ({1'b0, x_q} >= H_HS_BEG) && ({1'b0, x_q} < H_HS_END);
  assign vs_raw    = ({1'b0, y_q} >= V_VS_BEG) && ({1'b0, y_q} < V_VS_END);
  assign cur_flags = {act_raw, hs_raw, vs_raw};

  // Flags travel alongside the fetch so they meet the returned pixel byte.
  generate
    if (PIPE > 0) begin : g_dly
      logic [2:0] dly_q [PIPE];
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          for (int i = 0; i < PIPE; i++) dly_q[i] <= '0;
        end else if (pix_ce) begin
          dly_q[0] <= cur_flags;
          for (int i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign out_flags = dly_q[PIPE-1];
    end else begin : g_nodly
      assign out_flags = cur_flags;
    end
  endgenerate

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (EN) div_d = div_last ? '0 : div_q + DIV_W'(1);
    if (pix_ce) begin
      x_d = x_last ? '0 : x_q + COORD_W'(1);
      if (x_last) y_d = y_last ? '0 : y_q + COORD_W'(1);
      rgb_d = out_flags[2] ? PIXEL_IN : 8'h00;
      hs_d  = out_flags[1] ? HS_POL : ~HS_POL;
      vs_d  = out_flags[0] ? VS_POL : ~VS_POL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= 8'h00;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign XCOORD      = x_q;
  assign YCOORD      = y_q;
  assign FETCH_VALID = act_raw;
  assign PIX_CE      = pix_ce;
  assign LINE_START  = pix_ce && (x_q == '0);
  assign FRAME_START = pix_ce && (x_q == '0) && (y_q == '0);
  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign R           = rgb_q[7:5];
  assign G           = rgb_q[4:2];
  assign B           = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (full-width line with short frame, and a tiny
// raster with PIPE=0) checked every cycle against a tick-count model plus directed points.
module tb_vga_timing_gen;

  typedef struct packed {
    int dv; int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb; int pipe;
    bit hpol; bit vpol;
  } cfg_t;

  localparam cfg_t CA = '{dv:2, ha:640, hf:16, hs:96, hb:48, va:6, vf:2, vs:2, vb:2,
                          pipe:2, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CB = '{dv:3, ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1,
                          pipe:0, hpol:1'b1, vpol:1'b0};

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n = 1'b0, a_en = 1'b0;
  logic [7:0] a_px = 8'h00;
  logic [10:0] a_x, a_y;
  logic a_fv, a_ce, a_ls, a_fs, a_hs, a_vs;
  logic [2:0] a_r, a_g;
  logic [1:0] a_b;
  bit a_rnd = 1'b1;

  logic b_rst_n = 1'b0, b_en = 1'b0;
  logic [7:0] b_px = 8'h00;
  logic [3:0] b_x, b_y;
  logic b_fv, b_ce, b_ls, b_fs, b_hs, b_vs;
  logic [2:0] b_r, b_g;
  logic [1:0] b_b;
  bit b_rnd = 1'b1;

  vga_timing_gen #(
    .CLK_DIV(CA.dv), .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
    .HS_POL(CA.hpol), .VS_POL(CA.vpol), .PIPE(CA.pipe), .COORD_W(11)
  ) u_a (
    .CLK(clk), .RST_N(a_rst_n), .EN(a_en), .PIXEL_IN(a_px),
    .XCOORD(a_x), .YCOORD(a_y), .FETCH_VALID(a_fv), .PIX_CE(a_ce),
    .LINE_START(a_ls), .FRAME_START(a_fs), .HSYNC(a_hs), .VSYNC(a_vs),
    .R(a_r), .G(a_g), .B(a_b)
  );

  vga_timing_gen #(
    .CLK_DIV(CB.dv), .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
    .HS_POL(CB.hpol), .VS_POL(CB.vpol), .PIPE(CB.pipe), .COORD_W(4)
  ) u_b (
    .CLK(clk), .RST_N(b_rst_n), .EN(b_en), .PIXEL_IN(b_px),
    .XCOORD(b_x), .YCOORD(b_y), .FETCH_VALID(b_fv), .PIX_CE(b_ce),
    .LINE_START(b_ls), .FRAME_START(b_fs), .HSYNC(b_hs), .VSYNC(b_vs),
    .R(b_r), .G(b_g), .B(b_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Everything follows from the number of enabled cycles since reset: ticks = ecnt/div,
  // the fetch position is the tick number laid out on the raster, and the output stage
  // shows the position fetched PIPE ticks before the most recent tick.
  function automatic logic [63:0] model(input cfg_t c, input bit rst, input bit en,
                                        input int ecnt, input logic [7:0] lpx);
    int ht, vt, t, x, y, q, px, py;
    bit ce, fv, ls, fs, act, h, v;
    logic [7:0] rgb;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    t   = ecnt / c.dv;
    x   = t % ht;
    y   = (t / ht) % vt;
    ce  = rst && en && (ecnt % c.dv == c.dv - 1);
    ls  = ce && (x == 0);
    fs  = ls && (y == 0);
    fv  = (x < c.ha) && (y < c.va);
    act = 1'b0; h = 1'b0; v = 1'b0;
    q   = t - 1 - c.pipe;
    if (q >= 0) begin
      px  = q % ht;
      py  = (q / ht) % vt;
      act = (px < c.ha) && (py < c.va);
      h   = (px >= c.ha + c.hf) && (px < c.ha + c.hf + c.hs);
      v   = (py >= c.va + c.vf) && (py < c.va + c.vf + c.vs);
    end
    rgb = act ? lpx : 8'h00;
    return {18'd0, 16'(x), 16'(y), fv, ce, ls, fs,
            h ? c.hpol : !c.hpol, v ? c.vpol : !c.vpol, rgb};
  endfunction

  int a_ecnt = 0, b_ecnt = 0;
  logic [7:0] a_lpx = 8'h00, b_lpx = 8'h00;
  bit a_armed = 1'b0, b_armed = 1'b0;

  always @(posedge clk) begin
    if (!a_rst_n) begin
      a_ecnt <= 0; a_lpx <= 8'h00; a_armed <= 1'b1;
    end else if (a_en) begin
      if (a_ecnt % CA.dv == CA.dv - 1) a_lpx <= a_px;
      a_ecnt <= a_ecnt + 1;
    end
    if (!b_rst_n) begin
      b_ecnt <= 0; b_lpx <= 8'h00; b_armed <= 1'b1;
    end else if (b_en) begin
      if (b_ecnt % CB.dv == CB.dv - 1) b_lpx <= b_px;
      b_ecnt <= b_ecnt + 1;
    end
  end

  always @(negedge clk) begin
    if (a_armed)
      check("A_outputs", {18'd0, 16'(a_x), 16'(a_y), a_fv, a_ce, a_ls, a_fs, a_hs, a_vs,
                          a_r, a_g, a_b}, model(CA, a_rst_n, a_en, a_ecnt, a_lpx));
    if (b_armed)
      check("B_outputs", {18'd0, 16'(b_x), 16'(b_y), b_fv, b_ce, b_ls, b_fs, b_hs, b_vs,
                          b_r, b_g, b_b}, model(CB, b_rst_n, b_en, b_ecnt, b_lpx));
  end

  task automatic step_a(input bit r, input bit e);
    @(posedge clk); #1;
    a_rst_n = r; a_en = e;
    if (a_rnd) a_px = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic step_b(input bit r, input bit e);
    @(posedge clk); #1;
    b_rst_n = r; b_en = e;
    if (b_rnd) b_px = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic run_a();
    int n, cnt, last_x, last_y;
    repeat (3) step_a(1'b0, 1'b1);
    check("A_reset_state", {a_r, a_g, a_b, a_hs, a_vs, a_x, a_ce},
          {3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 11'd0, 1'b0});
    step_a(1'b1, 1'b1);
    check("A_first_cycle", {a_ce, a_x}, {1'b0, 11'd0});
    step_a(1'b1, 1'b1);
    check("A_second_cycle_ce", a_ce, 1'b1);
    step_a(1'b1, 1'b1);
    check("A_x_after_first_tick", a_x, 11'd1);

    a_rnd = 1'b0; a_px = 8'hA5;
    n = 0;
    while (!(a_x == 11'd300 && a_y == 11'd5) && n < 20000) begin step_a(1'b1, 1'b1); n++; end
    check("A_reach_300_5", n < 20000, 1'b1);
    check("A_rgb_A5", {a_r, a_g, a_b}, {3'd5, 3'd1, 2'd1});
    a_px = 8'hFF;
    n = 0;
    while (a_x != 11'd500 && n < 1000) begin step_a(1'b1, 1'b1); n++; end
    check("A_rgb_FF_visible", {a_r, a_g, a_b}, {3'd7, 3'd7, 2'd3});
    n = 0;
    while (a_x != 11'd700 && n < 1000) begin step_a(1'b1, 1'b1); n++; end
    check("A_rgb_FF_porch", {a_r, a_g, a_b}, 8'd0);

    n = 0;
    while (!(a_x == 11'd799 && a_y == 11'd5) && n < 1000) begin step_a(1'b1, 1'b1); n++; end
    check("A_reach_799_5", n < 1000, 1'b1);
    n = 0;
    while (a_x == 11'd799 && n < 10) begin step_a(1'b1, 1'b1); n++; end
    check("A_line_wrap_xy", {a_x, a_y}, {11'd0, 11'd6});
    cnt = 0; n = 0;
    while (a_x == 11'd0 && n < 10) begin cnt += int'(a_ls); step_a(1'b1, 1'b1); n++; end
    check("A_line_start_width", cnt, 1);

    a_rnd = 1'b1;
    last_x = -1; n = 0;
    while (a_hs != 1'b0 && n < 4000) begin
      if (a_ce) last_x = int'(a_x);
      step_a(1'b1, 1'b1); n++;
    end
    check("A_hsync_fall_fetch_x", last_x, 658);
    cnt = 0; n = 0;
    while (a_hs == 1'b0 && n < 1000) begin cnt += int'(a_ce); step_a(1'b1, 1'b1); n++; end
    check("A_hsync_ticks", cnt, 96);

    repeat (10) step_a(1'b1, 1'b0);
    repeat (1500) step_a(1'b1, $urandom_range(0, 7) != 0);

    last_x = -1; last_y = -1; n = 0;
    while (a_vs != 1'b0 && n < 20000) begin
      if (a_ce) begin last_x = int'(a_x); last_y = int'(a_y); end
      step_a(1'b1, 1'b1); n++;
    end
    check("A_vsync_fall_fetch_xy", {16'(last_x), 16'(last_y)}, {16'd2, 16'd8});
    cnt = 0; n = 0;
    while (a_vs == 1'b0 && n < 5000) begin cnt += int'(a_ce); step_a(1'b1, 1'b1); n++; end
    check("A_vsync_ticks", cnt, 1600);

    n = 0;
    while (!(a_x == 11'd799 && a_y == 11'd11) && n < 5000) begin step_a(1'b1, 1'b1); n++; end
    check("A_reach_799_11", n < 5000, 1'b1);
    n = 0;
    while (a_x == 11'd799 && n < 10) begin step_a(1'b1, 1'b1); n++; end
    check("A_frame_wrap_xy", {a_x, a_y}, 22'd0);
    cnt = 0; n = 0;
    while (a_x == 11'd0 && n < 10) begin cnt += int'(a_fs); step_a(1'b1, 1'b1); n++; end
    check("A_frame_start_width", cnt, 1);

    repeat (300) step_a(1'b1, $urandom_range(0, 3) != 0);
  endtask

  task automatic run_b();
    int n;
    repeat (3) step_b(1'b0, 1'b1);
    step_b(1'b1, 1'b1);
    n = 0;
    while (!(b_x == 4'd6 && b_y == 4'd3) && n < 1000) begin step_b(1'b1, 1'b1); n++; end
    check("B_reach_6_3", n < 1000, 1'b1);
    step_b(1'b0, 1'b1);
    check("B_strobes_quiet_in_reset", {b_ce, b_ls, b_fs}, 3'd0);
    step_b(1'b1, 1'b1);
    check("B_reset_values", {b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_fv, b_ce},
          {4'd0, 4'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    n = 0;
    while (!b_fs && n < 20) begin step_b(1'b1, 1'b1); n++; end
    check("B_first_frame_start", b_fs, 1'b1);
    n = 0;
    do begin step_b(1'b1, 1'b1); n++; end while (!b_fs && n < 400);
    check("B_frame_period", n, 252);

    repeat (1500) step_b($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
